fetch_aligner: RTL and testbench

- Instruction-fetch front end between the I-cache interface and the IF/ID register of the RISC-V pipeline.
- Fetches word-aligned 32-bit lines and realigns the RVC mixed 16/32-bit stream, including 32-bit instructions that straddle a word boundary.
- Presents one instruction per cycle with its PC and a compressed flag.
- Decompression is done downstream; this block only aligns.

---
 rtl/fetch_aligner.sv | 143 ++++++++++++++
 tb/tb_fetch_aligner.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_aligner.sv
// Instruction-fetch aligner: turns word-aligned I-cache reads into a stream of
// RVC 16-bit and 32-bit instructions, including 32-bit ones straddling two words.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        icache_ren,
  output logic [29:0] icache_addr,
  input  logic        icache_stall,
  input  logic [31:0] icache_rdata,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        is_compressed_o,
  output logic        instr_valid_o
);

  typedef enum logic [1:0] {StAlign, StBuf, StSkip} state_e;

  localparam logic [31:0] ResetPcEven = RESET_PC & ~32'd1;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [29:0] fetch_addr_q, fetch_addr_d;
  logic [15:0] buf_half_q, buf_half_d;

  logic [31:0] w;
  logic        w_comp;
  logic        buf_comp;
  logic        advance;

  // Undo bus byte order so W[15:0] is the halfword at pc[1] = 0.
  assign w        = {icache_rdata[7:0], icache_rdata[15:8],
                     icache_rdata[23:16], icache_rdata[31:24]};
  assign w_comp   = (w[1:0] != 2'b11);
  assign buf_comp = (buf_half_q[1:0] != 2'b11);

  assign icache_addr = fetch_addr_q;
  assign instr_pc_o  = pc_q;
  assign advance     = instr_valid_o & ~stall_i;

  always_comb begin
    instr_valid_o   = 1'b0;
    instr_o         = 32'h0;
    is_compressed_o = 1'b0;
    icache_ren      = 1'b1;
    unique case (state_q)
      StAlign: begin
        instr_valid_o = ~icache_stall;
        if (w_comp) begin
          instr_o         = {16'h0, w[15:0]};
          is_compressed_o = 1'b1;
        end else begin
          instr_o = w;
        end
      end
      StBuf: begin
        if (buf_comp) begin
          // Whole instruction already buffered; no word needed this cycle.
          instr_valid_o   = 1'b1;
          instr_o         = {16'h0, buf_half_q};
          is_compressed_o = 1'b1;
          icache_ren      = 1'b0;
        end else begin
          instr_valid_o = ~icache_stall;
          instr_o       = {w[15:0], buf_half_q};
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      instr_valid_o   = 1'b0;
      is_compressed_o = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    buf_half_d   = buf_half_q;
    if (redirect_i) begin
      pc_d         = redirect_pc_i & ~32'd1;
      fetch_addr_d = redirect_pc_i[31:2];
      buf_half_d   = 16'h0;
      state_d      = redirect_pc_i[1] ? StSkip : StAlign;
    end else begin
      unique case (state_q)
        StAlign: begin
          if (advance) begin
            fetch_addr_d = fetch_addr_q + 30'd1;
            if (w_comp) begin
              buf_half_d = w[31:16];
              pc_d       = pc_q + 32'd2;
              state_d    = StBuf;
            end else begin
              pc_d = pc_q + 32'd4;
            end
          end
        end
        StBuf: begin
          if (advance) begin
            if (buf_comp) begin
              pc_d    = pc_q + 32'd2;
              state_d = StAlign;
            end else begin
              pc_d         = pc_q + 32'd4;
              buf_half_d   = w[31:16];
              fetch_addr_d = fetch_addr_q + 30'd1;
            end
          end
        end
        StSkip: begin
          // Consume the upper half of the target word; not gated by stall_i.
          if (!icache_stall) begin
            buf_half_d   = w[31:16];
            fetch_addr_d = fetch_addr_q + 30'd1;
            state_d      = StBuf;
          end
        end
        default: state_d = StAlign;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= ResetPcEven;
      fetch_addr_q <= ResetPcEven[31:2];
      buf_half_q   <= 16'h0;
      state_q      <= ResetPcEven[1] ? StSkip : StAlign;
    end else begin
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      buf_half_q   <= buf_half_d;
      state_q      <= state_d;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Bench for fetch_aligner: a byte-addressed memory model and a PC-level reference
// that derives each expected instruction directly from the halfwords at pc.
module tb_fetch_aligner;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_ren;
  logic [29:0] icache_addr;
  logic        icache_stall;
  logic [31:0] icache_rdata;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        is_compressed_o;
  logic        instr_valid_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] mem [256];
  logic [31:0] garbage;
  logic [31:0] mem_w;

  logic [31:0] m_pc;
  logic        m_skip;
  logic        m_init = 1'b0;

  always #5 clk = ~clk;

  fetch_aligner #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_ren     (icache_ren),
    .icache_addr    (icache_addr),
    .icache_stall   (icache_stall),
    .icache_rdata   (icache_rdata),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o),
    .is_compressed_o(is_compressed_o),
    .instr_valid_o  (instr_valid_o)
  );

  // Cache model: logical words stored as W, driven on the bus byte-swapped.
  always_comb begin
    mem_w        = mem[icache_addr[7:0]];
    icache_rdata = icache_stall ? garbage
                                : {mem_w[7:0], mem_w[15:8], mem_w[23:16], mem_w[31:24]};
  end

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] wd;
    wd = mem[a[9:2]];
    return a[1] ? wd[31:16] : wd[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (pc model %08h)", tag, got, exp, m_pc);
    end
  endtask

  // One clock: drive inputs at negedge, compare, then advance the reference.
  task automatic cycle(input logic rst, input logic red, input logic [31:0] tgt,
                       input logic st, input logic ist);
    logic [15:0] h;
    logic        comp;
    logic        v;
    logic [31:0] ei;
    logic [29:0] ea;
    @(negedge clk);
    rst_n         = rst;
    redirect_i    = red;
    redirect_pc_i = tgt;
    stall_i       = st;
    icache_stall  = ist;
    garbage       = $urandom;
    #1;
    v = 1'b0;
    comp = 1'b0;
    if (!rst) begin
      check("valid_in_reset", {31'h0, instr_valid_o}, 32'h0);
      check("comp_in_reset", {31'h0, is_compressed_o}, 32'h0);
    end else if (m_init) begin
      h    = half_at(m_pc);
      comp = (h[1:0] != 2'b11);
      ei   = comp ? {16'h0, h} : {half_at(m_pc + 32'd2), h};
      // A buffered compressed half needs no word; everything else waits on the cache.
      v    = !m_skip && (!ist || (m_pc[1] && comp));
      ea   = m_pc[31:2] + (m_skip ? 30'd0 : {29'd0, m_pc[1]});
      check("valid", {31'h0, instr_valid_o}, {31'h0, v});
      check("icache_addr", {2'b0, icache_addr}, {2'b0, ea});
      check("icache_ren", {31'h0, icache_ren}, {31'h0, !(!m_skip && m_pc[1] && comp)});
      if (v) begin
        check("instr", instr_o, ei);
        check("instr_pc", instr_pc_o, m_pc);
        check("compressed", {31'h0, is_compressed_o}, {31'h0, comp});
      end
    end
    if (!rst) begin
      m_pc   = RESET_PC & ~32'd1;
      m_skip = RESET_PC[1];
      m_init = 1'b1;
    end else if (m_init) begin
      if (red) begin
        m_pc   = tgt & ~32'd1;
        m_skip = tgt[1];
      end else if (m_skip) begin
        if (!ist) m_skip = 1'b0;
      end else if (v && !st) begin
        m_pc = m_pc + (comp ? 32'd2 : 32'd4);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic clear_mem(input logic [31:0] fill);
    for (int i = 0; i < 256; i++) mem[i] = fill;
  endtask

  initial begin
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    stall_i = 1'b0; icache_stall = 1'b0; garbage = 32'h0;
    clear_mem(32'h0000_0013);

    // Straight 32-bit stream.
    do_reset();
    run(4);

    // Two compressed then a 32-bit word.
    mem[0] = 32'h4585_4501; mem[1] = 32'h0000_0013;
    do_reset();
    run(3);

    // 32-bit instruction straddling words 0 and 1, then buffered compressed.
    mem[0] = 32'h0513_4501; mem[1] = 32'h4501_00A0;
    do_reset();
    run(4);

    // Redirect to an odd-half target: one bubble, then 0x4585 @0x102.
    mem[8'h40] = 32'h4585_0013;
    cycle(1'b1, 1'b1, 32'h0000_0102, 1'b0, 1'b0);
    run(3);

    // Cache stall then consumer stall in the aligned state.
    clear_mem(32'h0000_0013);
    do_reset();
    run(1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    run(3);

    // Redirect during a cache stall, then reset while a 32-bit low half is buffered.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0020, 1'b0, 1'b1);
    run(2);
    mem[0] = 32'h0513_4501; mem[1] = 32'h0000_0013;
    do_reset();
    run(1);
    do_reset();
    run(2);

    // Address wrap at the top of the space.
    cycle(1'b1, 1'b1, 32'hFFFF_FFFA, 1'b0, 1'b0);
    run(5);

    // Random program and random stall/redirect/reset traffic.
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic        r;
      logic        rd;
      logic [31:0] t;
      r  = ($urandom_range(0, 199) != 0);
      rd = ($urandom_range(0, 19) == 0);
      t  = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : 32'($urandom_range(0, 1023));
      cycle(r, rd, t, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
